// File: rtl/axis_axi_wr_master_if.sv
// Bundle of the command, AXI-Stream, AXI4 write and status channels of the
// stream-to-memory write master. The master modport is the master's own view;
// the slave modport is the view of whatever surrounds it.
interface axis_axi_wr_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int ID_WIDTH   = 8,
   parameter int LEN_WIDTH  = 16
) ();
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic [ID_WIDTH-1:0]   cmd_id;
   logic                  cmd_valid;
   logic                  cmd_ready;

   logic [DATA_WIDTH-1:0] s_axis_tdata;
   logic                  s_axis_tlast;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;

   logic [ID_WIDTH-1:0]   m_axi_awid;
   logic [ADDR_WIDTH-1:0] m_axi_awaddr;
   logic [7:0]            m_axi_awlen;
   logic [2:0]            m_axi_awsize;
   logic [1:0]            m_axi_awburst;
   logic                  m_axi_awlock;
   logic [3:0]            m_axi_awcache;
   logic [2:0]            m_axi_awprot;
   logic                  m_axi_awvalid;
   logic                  m_axi_awready;

   logic [DATA_WIDTH-1:0] m_axi_wdata;
   logic [STRB_WIDTH-1:0] m_axi_wstrb;
   logic                  m_axi_wlast;
   logic                  m_axi_wvalid;
   logic                  m_axi_wready;

   logic [ID_WIDTH-1:0]   m_axi_bid;
   logic [1:0]            m_axi_bresp;
   logic                  m_axi_bvalid;
   logic                  m_axi_bready;

   logic [ID_WIDTH-1:0]   status_id;
   logic [1:0]            status_error;
   logic                  status_valid;
   logic                  status_ready;

   modport master (
      input  cmd_addr, cmd_len, cmd_id, cmd_valid,
      output cmd_ready,
      input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
      output s_axis_tready,
      output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
      output m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
      output m_axi_bready,
      output status_id, status_error, status_valid,
      input  status_ready
   );

   modport slave (
      output cmd_addr, cmd_len, cmd_id, cmd_valid,
      input  cmd_ready,
      output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
      input  s_axis_tready,
      input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
      input  m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bid, m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready,
      input  status_id, status_error, status_valid,
      output status_ready
   );
endinterface

// File: rtl/axis_axi_wr_master.sv
// Stream-to-memory write master: takes (addr, len, id) commands, pulls words
// from AXI-Stream and writes them as INCR bursts, one burst in flight at a
// time, then returns one status word per command.
// Optional macro AXIS_AXI_WR_MASTER_4K_SPLIT_EN: when defined, bursts are also
// cut at 4 KB boundaries; otherwise only remaining words and MAX_BURST_LEN cap them.
module axis_axi_wr_master #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 16,
   parameter int STRB_WIDTH    = DATA_WIDTH / 8,
   parameter int ID_WIDTH      = 8,
   parameter int LEN_WIDTH     = 16,
   parameter int MAX_BURST_LEN = 16
) (
   input logic                  clk,
   input logic                  rst,
   axis_axi_wr_master_if.master bus
);
   localparam int SIZE = $clog2(STRB_WIDTH);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, STATUS} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [31:0]           remaining_reg;
   logic [ID_WIDTH-1:0]   id_reg;
   logic [1:0]            err_reg;
   logic [8:0]            beat_cnt_reg;
   logic                  cmd_ready_reg, awvalid_reg, bready_reg, status_valid_reg;

   logic [31:0] cap_w, beats_w;
   logic        cmd_fire, aw_fire, w_fire, b_fire, st_fire;
   logic        last_beat, final_word;
   logic        unused_bid;

   // Beats in the current burst are a pure function of the address and the
   // remaining count, both of which hold still from ADDR through RESP.
`ifdef AXIS_AXI_WR_MASTER_4K_SPLIT_EN
   logic [11:0] addr_lo;
   logic [31:0] bnd_w;
   assign addr_lo = 12'(addr_reg);
   // Burst size limited by remaining words, the burst cap and the 4 KB page.
   always_comb begin
      cap_w   = (remaining_reg > 32'(MAX_BURST_LEN)) ? 32'(MAX_BURST_LEN) : remaining_reg;
      bnd_w   = (32'd4096 - 32'(addr_lo)) >> SIZE;
      beats_w = (bnd_w < cap_w) ? bnd_w : cap_w;
   end
`else
   // Burst size limited by remaining words and the burst cap.
   always_comb begin
      cap_w   = (remaining_reg > 32'(MAX_BURST_LEN)) ? 32'(MAX_BURST_LEN) : remaining_reg;
      beats_w = cap_w;
   end
`endif

   assign cmd_fire   = cmd_ready_reg && bus.cmd_valid;
   assign aw_fire    = awvalid_reg && bus.m_axi_awready;
   assign w_fire     = (state_reg == DATA) && bus.s_axis_tvalid && bus.m_axi_wready;
   assign b_fire     = bready_reg && bus.m_axi_bvalid;
   assign st_fire    = status_valid_reg && bus.status_ready;
   assign last_beat  = (32'(beat_cnt_reg) == beats_w - 32'd1);
   // The command's final word is the last beat of its last burst.
   assign final_word = last_beat && (remaining_reg == beats_w);
   assign unused_bid = ^bus.m_axi_bid;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic: one burst in flight, status returned once per command.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cmd_fire) state_next = ADDR;
         ADDR:    if (aw_fire) state_next = DATA;
         DATA:    if (w_fire && last_beat) state_next = RESP;
         RESP:    if (b_fire) state_next = (remaining_reg == beats_w) ? STATUS : ADDR;
         STATUS:  if (st_fire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake strobes registered from the next state so they are low in reset
   // and rise exactly one cycle after the event that enables them.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_ready_reg    <= 1'b0;
         awvalid_reg      <= 1'b0;
         bready_reg       <= 1'b0;
         status_valid_reg <= 1'b0;
      end else begin
         cmd_ready_reg    <= (state_next == IDLE);
         awvalid_reg      <= (state_next == ADDR);
         bready_reg       <= (state_next == RESP);
         status_valid_reg <= (state_next == STATUS);
      end
   end

   // Command datapath: address/remaining bookkeeping, beat counter, error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg      <= '0;
         remaining_reg <= '0;
         id_reg        <= '0;
         err_reg       <= '0;
         beat_cnt_reg  <= '0;
      end else begin
         if (cmd_fire) begin
            addr_reg      <= bus.cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
            remaining_reg <= 32'(bus.cmd_len) + 32'd1;
            id_reg        <= bus.cmd_id;
            err_reg       <= '0;
         end
         if (aw_fire) beat_cnt_reg <= '0;
         if (w_fire) begin
            beat_cnt_reg <= beat_cnt_reg + 9'd1;
            if (bus.s_axis_tlast != final_word) err_reg[0] <= 1'b1;
         end
         if (b_fire) begin
            if (bus.m_axi_bresp != 2'b00) err_reg[1] <= 1'b1;
            addr_reg      <= addr_reg + ADDR_WIDTH'(beats_w << SIZE);
            remaining_reg <= remaining_reg - beats_w;
         end
      end
   end

   assign bus.cmd_ready     = cmd_ready_reg;
   assign bus.m_axi_awid    = id_reg;
   assign bus.m_axi_awaddr  = addr_reg;
   assign bus.m_axi_awlen   = 8'(beats_w - 32'd1);
   assign bus.m_axi_awsize  = 3'(SIZE);
   assign bus.m_axi_awburst = 2'b01;
   assign bus.m_axi_awlock  = 1'b0;
   assign bus.m_axi_awcache = 4'b0011;
   assign bus.m_axi_awprot  = 3'b000;
   assign bus.m_axi_awvalid = awvalid_reg;

   // Write data is a straight pass-through of the stream while in DATA.
   assign bus.m_axi_wdata   = bus.s_axis_tdata;
   assign bus.m_axi_wstrb   = '1;
   assign bus.m_axi_wvalid  = (state_reg == DATA) && bus.s_axis_tvalid;
   assign bus.m_axi_wlast   = (state_reg == DATA) && last_beat;
   assign bus.s_axis_tready = (state_reg == DATA) && bus.m_axi_wready;

   assign bus.m_axi_bready  = bready_reg;
   assign bus.status_id     = id_reg;
   assign bus.status_error  = err_reg;
   assign bus.status_valid  = status_valid_reg;
endmodule

// File: tb/tb_axis_axi_wr_master.sv
// Directed bench for axis_axi_wr_master: a table of commands with expected
// burst splits, plus sequences for backpressure, error reporting and reset.
module tb_axis_axi_wr_master;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axis_axi_wr_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .LEN_WIDTH(16)) bus ();

   axis_axi_wr_master #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .LEN_WIDTH(16), .MAX_BURST_LEN(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [15:0]      addr;
      logic [15:0]      len;
      int               nb;
      logic [3:0][7:0]  awlen;
      logic [3:0][15:0] awaddr;
      logic [31:0]      base;
   } vec_t;

   vec_t vecs [7];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]  aw_len_q [$];
   logic [15:0] aw_addr_q [$];
   int          aw_cyc_q [$];
   logic [31:0] w_data_q [$];
   logic        w_last_q [$];
   logic [1:0]  st_err_q [$];
   logic [7:0]  st_id_q [$];
   logic [31:0] ram [0:16383];

   int   aw_field_bad = 0;
   int   wptr = 0;
   int   b_idx = 0;
   int   err_burst = -1;
   bit   wr_toggle = 1'b0;
   logic [7:0] exp_id = 8'h00;
   bit   aw_fire_f, w_fire_f, wlast_fire_f, b_fire_f;

   task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s/%s got=%0h want=%0h", tag, what, act, exp);
      end
   endtask

   task automatic timeout(input string tag, input string what);
      total++;
      bad++;
      $display("FAIL %s/%s got=timeout want=handshake", tag, what);
   endtask

   task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] l, input int nb,
                          input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                          input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                          input logic [31:0] base);
      vecs[i].addr      = a;
      vecs[i].len       = l;
      vecs[i].nb        = nb;
      vecs[i].awlen     = '0;
      vecs[i].awaddr    = '0;
      vecs[i].awlen[0]  = l0;
      vecs[i].awlen[1]  = l1;
      vecs[i].awlen[2]  = l2;
      vecs[i].awaddr[0] = a0;
      vecs[i].awaddr[1] = a1;
      vecs[i].awaddr[2] = a2;
      vecs[i].base      = base;
   endtask

   // Handshakes are judged just before the rising edge at which they complete.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      aw_fire_f    = !rst && bus.m_axi_awvalid && bus.m_axi_awready;
      w_fire_f     = !rst && bus.m_axi_wvalid && bus.m_axi_wready;
      wlast_fire_f = w_fire_f && bus.m_axi_wlast;
      b_fire_f     = !rst && bus.m_axi_bvalid && bus.m_axi_bready;
      if (aw_fire_f) begin
         aw_len_q.push_back(bus.m_axi_awlen);
         aw_addr_q.push_back(bus.m_axi_awaddr);
         aw_cyc_q.push_back(cyc);
         if (bus.m_axi_awsize != 3'd2 || bus.m_axi_awburst != 2'b01 || bus.m_axi_awlock != 1'b0 ||
             bus.m_axi_awcache != 4'b0011 || bus.m_axi_awprot != 3'b000 || bus.m_axi_awid != exp_id)
            aw_field_bad++;
         wptr = int'(bus.m_axi_awaddr >> 2);
      end
      if (w_fire_f) begin
         w_data_q.push_back(bus.m_axi_wdata);
         w_last_q.push_back(bus.m_axi_wlast);
         if (bus.m_axi_wstrb != 4'hF) aw_field_bad++;
         ram[wptr] = bus.m_axi_wdata;
         wptr = (wptr + 1) & 16383;
      end
      if (!rst && bus.status_valid && bus.status_ready) begin
         st_err_q.push_back(bus.status_error);
         st_id_q.push_back(bus.status_id);
      end
   end

   // AXI slave responder: AW always ready, W ready optionally toggling, one B per burst.
   initial begin
      bus.m_axi_awready = 1'b1;
      bus.m_axi_wready  = 1'b1;
      bus.m_axi_bvalid  = 1'b0;
      bus.m_axi_bresp   = 2'b00;
      bus.m_axi_bid     = 8'h00;
      bus.status_ready  = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            bus.m_axi_bvalid = 1'b0;
         end else begin
            if (b_fire_f) bus.m_axi_bvalid = 1'b0;
            if (wlast_fire_f) begin
               bus.m_axi_bvalid = 1'b1;
               bus.m_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
               b_idx++;
            end
         end
         bus.m_axi_wready = wr_toggle ? ~bus.m_axi_wready : 1'b1;
      end
   end

   task automatic issue_cmd(input logic [15:0] addr, input logic [15:0] len, input logic [7:0] id,
                            output int cmd_cyc, output bit ok);
      ok = 1'b0;
      cmd_cyc = 0;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.cmd_id    = id;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            ok = 1'b1;
            cmd_cyc = cyc;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic send_words(input int n, input int tlast_idx, input logic [31:0] base,
                             input bit gaps, output bit ok);
      ok = 1'b1;
      for (int i = 0; i < n && ok; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            bus.s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         bus.s_axis_tdata  = base + 32'(i);
         bus.s_axis_tlast  = (i == tlast_idx);
         bus.s_axis_tvalid = 1'b1;
         ok = 1'b0;
         for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (bus.s_axis_tready) begin
               ok = 1'b1;
               break;
            end
         end
         @(posedge clk);
         #1;
      end
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input logic [15:0] addr, input logic [15:0] len,
                                input logic [7:0] id, input logic [31:0] base, input int tlast_idx,
                                input bit gaps, input bit toggle, input int errb, input int exp_nb,
                                input logic [3:0][7:0] exp_len, input logic [3:0][15:0] exp_addr,
                                input logic [1:0] exp_err);
      bit ok;
      bit got_status;
      bit exp_last;
      int n, cmd_cyc, b, j;
      aw_len_q.delete();
      aw_addr_q.delete();
      aw_cyc_q.delete();
      w_data_q.delete();
      w_last_q.delete();
      st_err_q.delete();
      st_id_q.delete();
      aw_field_bad = 0;
      b_idx        = 0;
      err_burst    = errb;
      wr_toggle    = toggle;
      exp_id       = id;
      n = int'(len) + 1;
      issue_cmd(addr, len, id, cmd_cyc, ok);
      if (!ok) begin
         timeout(tag, "cmd");
         wr_toggle = 1'b0;
         return;
      end
      send_words(n, tlast_idx, base, gaps, ok);
      if (!ok) timeout(tag, "stream");
      got_status = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (bus.status_valid && bus.status_ready) begin
            got_status = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      wr_toggle = 1'b0;
      if (!got_status) timeout(tag, "status");
      chk(tag, "aw_count", aw_len_q.size(), exp_nb);
      for (int k = 0; k < exp_nb && k < aw_len_q.size(); k++) begin
         chk(tag, $sformatf("awlen%0d", k), aw_len_q[k], exp_len[k]);
         chk(tag, $sformatf("awaddr%0d", k), aw_addr_q[k], exp_addr[k]);
      end
      if (aw_cyc_q.size() > 0) chk(tag, "cmd_to_aw", aw_cyc_q[0] - cmd_cyc, 1);
      chk(tag, "aw_fields", aw_field_bad, 0);
      chk(tag, "w_count", w_data_q.size(), n);
      b = 0;
      j = 0;
      for (int i = 0; i < n && i < w_data_q.size(); i++) begin
         exp_last = (b < 4) && (j == int'(exp_len[b]));
         chk(tag, $sformatf("wdata%0d", i), w_data_q[i], base + 32'(i));
         chk(tag, $sformatf("wlast%0d", i), w_last_q[i], exp_last);
         if (exp_last) begin
            b++;
            j = 0;
         end else begin
            j++;
         end
      end
      chk(tag, "status_count", st_err_q.size(), 1);
      if (st_err_q.size() > 0) begin
         chk(tag, "status_error", st_err_q[0], exp_err);
         chk(tag, "status_id", st_id_q[0], id);
      end
      chk(tag, "ram_first", ram[int'(addr >> 2)], base);
      $display("cmd %s addr=%04h len=%0d id=%02h bursts=%0d beats=%0d err=%0d",
               tag, addr, len, id, aw_len_q.size(), w_data_q.size(),
               (st_err_q.size() > 0) ? st_err_q[0] : 2'd3);
   endtask

   initial begin
      bit ok;
      int cmd_cyc, hs;
      logic [3:0][7:0]  el;
      logic [3:0][15:0] ea;

      set_vec(0, 16'h0100, 16'd0,  1, 8'd0,  8'd0,  8'd0, 16'h0100, 16'h0000, 16'h0000, 32'hA5A5A5A5);
      set_vec(1, 16'h0000, 16'd39, 3, 8'd15, 8'd15, 8'd7, 16'h0000, 16'h0040, 16'h0080, 32'h11000000);
`ifdef AXIS_AXI_WR_MASTER_4K_SPLIT_EN
      set_vec(2, 16'h0FF0, 16'd7,  2, 8'd3,  8'd3,  8'd0, 16'h0FF0, 16'h1000, 16'h0000, 32'h22000000);
      set_vec(4, 16'hFFF8, 16'd3,  2, 8'd1,  8'd1,  8'd0, 16'hFFF8, 16'h0000, 16'h0000, 32'h44000000);
`else
      set_vec(2, 16'h0FF0, 16'd7,  1, 8'd7,  8'd0,  8'd0, 16'h0FF0, 16'h0000, 16'h0000, 32'h22000000);
      set_vec(4, 16'hFFF8, 16'd3,  1, 8'd3,  8'd0,  8'd0, 16'hFFF8, 16'h0000, 16'h0000, 32'h44000000);
`endif
      set_vec(3, 16'h0102, 16'd2,  1, 8'd2,  8'd0,  8'd0, 16'h0100, 16'h0000, 16'h0000, 32'h33000000);
      set_vec(5, 16'h0200, 16'd15, 1, 8'd15, 8'd0,  8'd0, 16'h0200, 16'h0000, 16'h0000, 32'h55000000);
      set_vec(6, 16'h0300, 16'd16, 2, 8'd15, 8'd0,  8'd0, 16'h0300, 16'h0340, 16'h0000, 32'h66000000);

      rst = 1'b1;
      bus.cmd_addr      = '0;
      bus.cmd_len       = '0;
      bus.cmd_id        = '0;
      bus.cmd_valid     = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset", "cmd_ready", bus.cmd_ready, 0);
      chk("reset", "awvalid", bus.m_axi_awvalid, 0);
      chk("reset", "wvalid", bus.m_axi_wvalid, 0);
      chk("reset", "wlast", bus.m_axi_wlast, 0);
      chk("reset", "bready", bus.m_axi_bready, 0);
      chk("reset", "tready", bus.s_axis_tready, 0);
      chk("reset", "status_valid", bus.status_valid, 0);
      chk("reset", "status_error", bus.status_error, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset", "cmd_ready_hold", bus.cmd_ready, 0);
      @(negedge clk);
      chk("reset", "cmd_ready_rise", bus.cmd_ready, 1);
      @(posedge clk);
      #1;

      for (int v = 0; v < 7; v++) begin
         run_and_check($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, 8'(v + 1), vecs[v].base,
                       int'(vecs[v].len), 1'b0, 1'b0, -1, vecs[v].nb, vecs[v].awlen, vecs[v].awaddr, 2'b00);
         repeat (2) @(posedge clk);
         #1;
      end

      // Backpressure on both sides of a 16-beat burst.
      el = '0; ea = '0;
      el[0] = 8'd15; ea[0] = 16'h0400;
      run_and_check("backpressure", 16'h0400, 16'd15, 8'h40, 32'h77000000, 15, 1'b1, 1'b1, -1, 1, el, ea, 2'b00);

      // Error response on the second of three bursts.
      el = '0; ea = '0;
      el[0] = 8'd15; el[1] = 8'd15; el[2] = 8'd7;
      ea[0] = 16'h2000; ea[1] = 16'h2040; ea[2] = 16'h2080;
      run_and_check("bresp_err", 16'h2000, 16'd39, 8'h50, 32'h88000000, 39, 1'b0, 1'b0, 1, 3, el, ea, 2'b10);

      // tlast on word 5 of 8: flagged, all 8 words still written.
      el = '0; ea = '0;
      el[0] = 8'd7; ea[0] = 16'h0800;
      run_and_check("tlast_err", 16'h0800, 16'd7, 8'h60, 32'h99000000, 4, 1'b0, 1'b0, -1, 1, el, ea, 2'b01);

      // Reset while a burst is mid-way through DATA.
      issue_cmd(16'h0500, 16'd15, 8'h70, cmd_cyc, ok);
      if (!ok) timeout("mid_reset", "cmd");
      bus.s_axis_tdata  = 32'hDEAD0000;
      bus.s_axis_tvalid = 1'b1;
      hs = 0;
      for (int k = 0; k < 200 && hs < 3; k++) begin
         @(negedge clk);
         if (bus.s_axis_tready) hs++;
         @(posedge clk);
         #1;
      end
      if (hs < 3) timeout("mid_reset", "beats");
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_reset", "awvalid", bus.m_axi_awvalid, 0);
      chk("mid_reset", "wvalid", bus.m_axi_wvalid, 0);
      chk("mid_reset", "bready", bus.m_axi_bready, 0);
      chk("mid_reset", "status_valid", bus.status_valid, 0);
      $display("cmd mid_reset beats_before_reset=%0d", hs);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      el = '0; ea = '0;
      el[0] = 8'd5; ea[0] = 16'h0600;
      run_and_check("after_reset", 16'h0600, 16'd5, 8'h71, 32'hBB000000, 5, 1'b0, 1'b0, -1, 1, el, ea, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/axis_axi_wr_master.md
# axis_axi_wr_master

Stream-to-memory write master that sits directly upstream of the AXI4 RAM slave. It accepts a write command (address, word count, ID), pulls data words from an AXI-Stream input, and issues INCR write bursts on an AXI4 master write port. Each burst is limited by a burst-length cap and, optionally, by 4 KB boundaries. One status word is returned per command.

## Interface
- DATA_WIDTH, 32, AXI and stream data width; power-of-two bytes
- ADDR_WIDTH, 16, AXI address width
- STRB_WIDTH, DATA_WIDTH/8, strobe width
- ID_WIDTH, 8, AXI ID width
- LEN_WIDTH, 16, command length width
- MAX_BURST_LEN, 16, maximum beats per burst (1..256)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored
- cmd_len  in  LEN_WIDTH  word count minus 1
- cmd_id  in  ID_WIDTH  ID driven on all bursts of the command
- cmd_valid / cmd_ready  in / out  1  command handshake
- s_axis_tdata  in  DATA_WIDTH  write data
- s_axis_tlast  in  1  end of packet
- s_axis_tvalid / s_axis_tready  in / out  1  stream handshake
- m_axi_awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awlock, awcache[3:0], awprot[2:0], awvalid  out; m_axi_awready  in
- m_axi_wdata, wstrb, wlast, wvalid  out; m_axi_wready  in
- m_axi_bid[ID_WIDTH], bresp[1:0], bvalid  in; m_axi_bready  out
- status_id  out  ID_WIDTH  ID of the completed command
- status_error  out  2  bit0 tlast mismatch, bit1 nonzero bresp
- status_valid / status_ready  out / in  1  status handshake

## Operation
- States: IDLE, ADDR, DATA, RESP, STATUS. One burst outstanding at a time.
- IDLE: cmd_ready=1. On handshake, latch addr (aligned), remaining=cmd_len+1, id; clear error flags; go to ADDR.
- Burst beats = min(remaining, MAX_BURST_LEN, words to next 4 KB boundary [macro only]).
  - Words to boundary = (4096 − addr[11:0]) / STRB_WIDTH, using only the implemented address bits when ADDR_WIDTH<12.
- ADDR: awvalid=1, awlen=beats−1, awsize=log2(STRB_WIDTH), awburst=01, awlock=0, awcache=0011, awprot=000. Fields are stable until awready; then go to DATA.
- DATA: m_axi_wvalid=s_axis_tvalid; s_axis_tready=m_axi_wready; wdata=tdata; wstrb all ones; wlast on the final beat of the burst, from a beat counter.
  - Flag bit0 if tlast is seen on any beat other than the command's final word, or is absent on that final word. Data keeps flowing.
  - On the wlast handshake, go to RESP.
- RESP: bready=1. On bvalid, OR (bresp!=0) into bit1; addr += beats·STRB_WIDTH (mod 2^ADDR_WIDTH); remaining −= beats. Go to ADDR if remaining>0, else STATUS.
- STATUS: status_valid=1 with id and error held until status_ready, then IDLE.
- Outside DATA: s_axis_tready=0, wvalid=0. Outside RESP: bready=0. bid is ignored.

## Timing
- Reset values: cmd_ready=0, awvalid=0, wvalid=0, wlast=0, bready=0, s_axis_tready=0, status_valid=0, status_error=0, state IDLE. All are registered except the W/stream pass-through.
- cmd_ready rises the cycle after rst deasserts.
- Command accepted at cycle N → awvalid at N+1.
- AW handshake at M → W beats may complete from M+1.
- wlast handshake at K → bready at K+1.
- B handshake at J → next awvalid or status_valid at J+1.
- W path is combinational: zero added latency, one beat per cycle at full throughput.
- Reset mid-burst returns to IDLE next cycle. The downstream slave must be reset together with this block.
- cmd_len up to 2^LEN_WIDTH words; address wrap at 2^ADDR_WIDTH is silent.

## Configuration
- AXIS_AXI_WR_MASTER_4K_SPLIT_EN defined: bursts never cross a 4 KB boundary.
- AXIS_AXI_WR_MASTER_4K_SPLIT_EN undefined: the 4 KB term is removed and bursts are capped only by remaining and MAX_BURST_LEN.

## Test plan
- Single word: cmd addr 0x0100, len 0, tdata 0xA5A5A5A5 with tlast → one AW (awlen 0, awaddr 0x0100), one W with wlast; status_error 0; RAM word 0x0100 reads 0xA5A5A5A5.
- Split by cap: addr 0x0000, len 39, MAX_BURST_LEN 16 → AW awlen 15/15/7 at 0x0000/0x0040/0x0080; one status, error 0.
- 4 KB crossing (ADDR_WIDTH 16): addr 0x0FF0, len 7 → with macro, bursts awlen 3 @0x0FF0 and awlen 3 @0x1000; without macro, one burst awlen 7 @0x0FF0.
- Backpressure: wready toggles 1/0 and tvalid has random gaps on a 16-beat burst → exactly 16 W handshakes, data in order, wlast on beat 16 only.
- Errors: bresp 10 on the second of 3 bursts → status_error[1]=1. tlast on word 5 of 8 → status_error[0]=1, all 8 words still written.
- Reset during DATA → next cycle awvalid/wvalid/bready/status_valid are 0; a new command then completes normally.
